// File: rtl/load_seq_pkg.sv
// load_seq_pkg: shared state encoding and parameter defaults for the A/B load sequencer
package load_seq_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_TIMEOUT = 255;
  typedef enum logic [2:0] {
    IDLE,
    WAIT_A,
    LOAD_A,
    WAIT_B,
    LOAD_B,
    DONE,
    ERR
  } state_e;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: saturating wait counter flagging the last allowed cycle before timeout
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = clear ? '0 : (enable && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/load_sequencer.sv
// load_sequencer: captures operand A then B from a valid/ready source and pulses register load enables
module load_sequencer
  import load_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] num,
  input  logic             num_valid,
  output logic             num_ready,
  output logic [WIDTH-1:0] num_out,
  output logic             okA,
  output logic             okB,
  output logic             done,
  output logic             err_timeout,
  output logic             busy
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic hs, expired;
  assign num_ready = (state_q == WAIT_A) || (state_q == WAIT_B);
  assign hs = num_valid & num_ready;
  assign num_d = (hs && !abort) ? num : num_q;
  assign num_out = num_q;
  assign okA = state_q == LOAD_A;
  assign okB = state_q == LOAD_B;
  assign done = state_q == DONE;
  assign err_timeout = state_q == ERR;
  assign busy = state_q != IDLE;
  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clear(state_q != WAIT_B),
    .enable((state_q == WAIT_B) && !hs),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? WAIT_A : IDLE;
      WAIT_A:  state_d = hs ? LOAD_A : WAIT_A;
      LOAD_A:  state_d = WAIT_B;
      WAIT_B:  state_d = hs ? LOAD_B : expired ? ERR : WAIT_B;
      LOAD_B:  state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q <= '0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
    end
  end
endmodule

// File: tb/tb_load_sequencer.sv
// tb_load_sequencer: directed vector table, reset corner case and random run against a phase-level model
module tb_load_sequencer;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst_n, start, abort, num_valid, num_ready, okA, okB, done, err_timeout, busy;
  logic [7:0] num, num_out;
  logic [13:0] dut_o;
  int n_chk = 0;
  int n_fail = 0;
  int m_ph, m_wait;
  logic [7:0] m_num;
  typedef struct {
    logic s, a, v;
    logic [7:0] n;
    logic [13:0] e;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  load_sequencer #(.WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num(num),
    .num_valid(num_valid), .num_ready(num_ready), .num_out(num_out),
    .okA(okA), .okB(okB), .done(done), .err_timeout(err_timeout), .busy(busy)
  );
  assign dut_o = {num_ready, okA, okB, done, err_timeout, busy, num_out};

  // phases: 0 idle, 1 awaiting A, 2 A loaded, 3 awaiting B, 4 B loaded, 5 finished, 6 timed out
  function automatic logic [13:0] m_out();
    return {m_ph == 1 || m_ph == 3, m_ph == 2, m_ph == 4, m_ph == 5, m_ph == 6, m_ph != 0, m_num};
  endfunction

  task automatic m_step(input logic s, input logic a, input logic v, input logic [7:0] n);
    bit take;
    take = v && (m_ph == 1 || m_ph == 3);
    if (a) m_ph = 0;
    else if (m_ph == 0) m_ph = s ? 1 : 0;
    else if (m_ph == 1) begin
      if (take) begin m_num = n; m_ph = 2; end
    end else if (m_ph == 2) begin m_ph = 3; m_wait = 0; end
    else if (m_ph == 3) begin
      if (take) begin m_num = n; m_ph = 4; end
      else if (m_wait == TO - 1) m_ph = 6;
      else m_wait++;
    end else if (m_ph == 4) m_ph = 5;
    else m_ph = 0;
  endtask

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy/okA/okB/done/err/busy=%b num_out=%h, expected %b num_out=%h",
               name, act[13:8], act[7:0], exp[13:8], exp[7:0]);
    end
  endtask

  task automatic step(input logic s, input logic a, input logic v, input logic [7:0] n);
    start = s; abort = a; num_valid = v; num = n;
    @(posedge clk);
    m_step(s, a, v, n);
    #1;
    chk("model", dut_o, m_out());
  endtask

  function automatic vec_t mk(input logic s, a, v, input logic [7:0] n,
                              input logic r, oa, ob, d, er, bu, input logic [7:0] no);
    vec_t t;
    t.s = s; t.a = a; t.v = v; t.n = n;
    t.e = {r, oa, ob, d, er, bu, no};
    return t;
  endfunction

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; num_valid = 0; num = '0;
    m_ph = 0; m_wait = 0; m_num = '0;
    #3 chk("reset", dut_o, 14'h0);
    #9 rst_n = 1'b1;
    // basic A/B sequence, handshakes three cycles apart
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h00));
    tbl.push_back(mk(0, 0, 1, 8'h12, 0, 1, 0, 0, 0, 1, 8'h12));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h12));
    tbl.push_back(mk(0, 0, 1, 8'h34, 0, 0, 1, 0, 0, 1, 8'h34));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h34));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h34));
    // valid in idle ignored, start in WAIT_B ignored, abort in WAIT_B
    tbl.push_back(mk(0, 0, 1, 8'h99, 0, 0, 0, 0, 0, 0, 8'h34));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h34));
    tbl.push_back(mk(0, 0, 1, 8'hAA, 0, 1, 0, 0, 0, 1, 8'hAA));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'hAA));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'hAA));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hAA));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hAA));
    // abort while in LOAD_A: okA already pulsed
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'hAA));
    tbl.push_back(mk(0, 0, 1, 8'hBB, 0, 1, 0, 0, 0, 1, 8'hBB));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'hBB));
    // timeout after four WAIT_B cycles
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'hBB));
    tbl.push_back(mk(0, 0, 1, 8'h55, 0, 1, 0, 0, 0, 1, 8'h55));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h55));
    // handshake in the last WAIT_B cycle beats the timeout
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h55));
    tbl.push_back(mk(0, 0, 1, 8'h77, 0, 1, 0, 0, 0, 1, 8'h77));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h77));
    tbl.push_back(mk(0, 0, 1, 8'h66, 0, 0, 1, 0, 0, 1, 8'h66));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h66));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 8'h66));
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].n);
      chk($sformatf("vec[%0d]", i), dut_o, tbl[i].e);
    end
    // asynchronous reset while in LOAD_B
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hC1);
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'hC2);
    chk("pre_reset_okB", {13'h0, okB}, 14'h1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_o, 14'h0);
    m_ph = 0; m_wait = 0; m_num = '0;
    #2 rst_n = 1'b1;
    step(0, 0, 0, 8'h00);
    chk("idle_after_reset", dut_o, 14'h0);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hA0);
    chk("post_reset_A", dut_o, {6'b010001, 8'hA0});
    step(0, 0, 0, 8'h00);
    step(0, 0, 1, 8'h0B);
    chk("post_reset_B", dut_o, {6'b001001, 8'h0B});
    step(0, 0, 0, 8'h00);
    chk("post_reset_done", dut_o, {6'b000101, 8'h0B});
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0, 8'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
